// File: rtl/palette_pkg.sv
// Shared types and constants for the palette lookup arbiter and related blocks.
package palette_pkg;

  localparam int PAL_IDX_W = 9;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb444_t;

  typedef enum logic {
    ARB,
    BURST
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N.
module rr_pick
  import palette_pkg::*;
#(
  parameter int N = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] gid,
  output logic            any
);

  int j;

  // Walk from ptr upward with explicit modulo so non-power-of-2 N wraps correctly.
  always_comb begin
    grant = '0;
    gid   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        gid      = ID_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/palette_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one palette lookup port.
// Colour is registered and returned one cycle after the grant, tagged with the owner ID.
//
// state | meaning
// ARB   | pick the next requester round-robin from ptr
// BURST | keep granting owner while it stays valid, up to BURST_MAX grants
module palette_arbiter
  import palette_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = PAL_IDX_W,
  parameter int BURST_MAX = 8,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_index,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [IDX_W-1:0]         pal_index,
  input  logic [3:0]               pal_red,
  input  logic [3:0]               pal_green,
  input  logic [3:0]               pal_blue,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [3:0]               rsp_red,
  output logic [3:0]               rsp_green,
  output logic [3:0]               rsp_blue
);

  localparam logic [7:0] BURST_LAST = 8'(BURST_MAX);

  arb_state_t        state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   owner;
  logic [7:0]        count;
  rgb444_t           rsp_rgb;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_gid;
  logic               pick_any;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gid;
  logic               any;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (int'(id) == NUM_REQ - 1) return '0;
    return id + 1'b1;
  endfunction

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .gid   (pick_gid),
    .any   (pick_any)
  );

  // Grant selection: round-robin pick in ARB, owner continuation in BURST; none during reset.
  always_comb begin
    grant = '0;
    gid   = owner;
    any   = 1'b0;
    if (!Reset) begin
      if (state == ARB) begin
        grant = pick_grant;
        gid   = pick_gid;
        any   = pick_any;
      end else if (req_valid[owner] && (count < BURST_LAST)) begin
        grant[owner] = 1'b1;
        any          = 1'b1;
      end
    end
  end

  assign req_ready = grant;

  // Route the granted requester's index to the ROM; zero when idle.
  always_comb begin
    pal_index = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) pal_index = req_index[i*IDX_W +: IDX_W];
    end
  end

  // Arbitration state plus the one-cycle registered response.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ARB;
      ptr       <= '0;
      owner     <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_rgb   <= '0;
    end else begin
      rsp_valid <= any;
      if (any) begin
        rsp_id  <= gid;
        rsp_rgb <= '{red: pal_red, green: pal_green, blue: pal_blue};
      end
      case (state)
        ARB: begin
          if (any) begin
            owner <= gid;
            count <= 8'd1;
            if (BURST_MAX > 1) state <= BURST;
            else               ptr   <= next_id(gid);
          end
        end
        BURST: begin
          if (any) begin
            count <= count + 8'd1;
            if (count + 8'd1 == BURST_LAST) begin
              ptr   <= next_id(owner);
              state <= ARB;
            end
          end else begin
            // Owner dropped out: hand off, costing one idle cycle.
            ptr   <= next_id(owner);
            state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign rsp_red   = rsp_rgb.red;
  assign rsp_green = rsp_rgb.green;
  assign rsp_blue  = rsp_rgb.blue;

endmodule

// File: tb/tb_palette_arbiter.sv
// Directed bench for palette_arbiter: BURST_MAX=8 instance plus a BURST_MAX=1 instance for rotation.
module tb_palette_arbiter;
  import palette_pkg::*;

  localparam int N  = 4;
  localparam int IW = 9;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  logic [N-1:0]    req_valid  = '0;
  logic [N-1:0]    req_valid1 = '0;
  logic [N*IW-1:0] req_index  = '0;

  logic [N-1:0]  ready,  ready1;
  logic [IW-1:0] pal_index, pal_index1;
  logic [3:0]    pal_red, pal_green, pal_blue;
  logic [3:0]    pal_red1, pal_green1, pal_blue1;
  logic          rsp_valid, rsp_valid1;
  logic [1:0]    rsp_id, rsp_id1;
  logic [3:0]    rsp_red, rsp_green, rsp_blue;
  logic [3:0]    rsp_red1, rsp_green1, rsp_blue1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0] idx_tab [4] = '{9'd5, 9'd300, 9'd13, 9'd511};

  function automatic logic [11:0] pal_model(input logic [8:0] idx);
    if (idx == 9'd13) return 12'hABB;
    return {idx[3:0], idx[7:4], idx[8], idx[2:0]};
  endfunction

  assign {pal_red,  pal_green,  pal_blue}  = pal_model(pal_index);
  assign {pal_red1, pal_green1, pal_blue1} = pal_model(pal_index1);

  always #5 Clk = ~Clk;

  palette_arbiter #(.NUM_REQ(N), .IDX_W(IW), .BURST_MAX(8)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_index(req_index),
    .req_ready(ready), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_red(rsp_red), .rsp_green(rsp_green), .rsp_blue(rsp_blue)
  );

  palette_arbiter #(.NUM_REQ(N), .IDX_W(IW), .BURST_MAX(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid1), .req_index(req_index),
    .req_ready(ready1), .pal_index(pal_index1),
    .pal_red(pal_red1), .pal_green(pal_green1), .pal_blue(pal_blue1),
    .rsp_valid(rsp_valid1), .rsp_id(rsp_id1),
    .rsp_red(rsp_red1), .rsp_green(rsp_green1), .rsp_blue(rsp_blue1)
  );

  task automatic test_reset();
    req_valid  = 4'hF;
    req_valid1 = 4'hF;
    #3;
    n_cmp++;
    if ({ready, ready1} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ready got=%b/%b want=0000/0000", ready, ready1);
    end
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_rsp got v=%b id=%0d rgb=%h%h%h want all zero",
               rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue);
    end
    req_valid  = '0;
    req_valid1 = '0;
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++;
      if ({ready, pal_index} !== 13'h0) begin
        n_fail++;
        $display("FAIL idle_grant cyc=%0d got ready=%b idx=%0d want 0/0", c, ready, pal_index);
      end
      @(posedge Clk); #1;
      n_cmp++;
      if ({rsp_valid, rsp_valid1} !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_rsp cyc=%0d got=%b%b want=00", c, rsp_valid, rsp_valid1);
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] oh;
    logic [1:0] g;
    req_valid1 = 4'hF;
    for (int i = 0; i < 12; i++) begin
      g  = 2'(i % 4);
      oh = 4'b0001 << g;
      #1;
      n_cmp++;
      if ({ready1, pal_index1} !== {oh, idx_tab[g]}) begin
        n_fail++;
        $display("FAIL rot_grant i=%0d got ready=%b idx=%0d want ready=%b idx=%0d",
                 i, ready1, pal_index1, oh, idx_tab[g]);
      end
      @(posedge Clk); #1;
      n_cmp++;
      if ({rsp_valid1, rsp_id1, rsp_red1, rsp_green1, rsp_blue1} !== {1'b1, g, pal_model(idx_tab[g])}) begin
        n_fail++;
        $display("FAIL rot_rsp i=%0d got v=%b id=%0d rgb=%h%h%h want v=1 id=%0d rgb=%h",
                 i, rsp_valid1, rsp_id1, rsp_red1, rsp_green1, rsp_blue1, g, pal_model(idx_tab[g]));
      end
    end
    req_valid1 = '0;
    @(posedge Clk); #1;
    n_cmp++;
    if (rsp_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rot_idle got v=%b want 0", rsp_valid1);
    end
  endtask

  task automatic test_burst_limit();
    req_valid = 4'b0100;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_cmp++;
      if ({ready, pal_index} !== {4'b0100, 9'd13}) begin
        n_fail++;
        $display("FAIL burst_grant i=%0d got ready=%b idx=%0d want ready=0100 idx=13", i, ready, pal_index);
      end
      @(posedge Clk); #1;
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue} !== {1'b1, 2'd2, 12'hABB}) begin
        n_fail++;
        $display("FAIL burst_rsp i=%0d got v=%b id=%0d rgb=%h%h%h want v=1 id=2 rgb=abb",
                 i, rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue);
      end
    end
    req_valid = '0;
    #1;
    @(posedge Clk); #1;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue} !== {1'b0, 2'd2, 12'hABB}) begin
      n_fail++;
      $display("FAIL burst_hold got v=%b id=%0d rgb=%h%h%h want v=0 id=2 rgb=abb",
               rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue);
    end
  endtask

  task automatic test_burst_abandon();
    // Pointer is 3 here; requester 1 wins and runs three burst grants.
    req_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (ready !== 4'b0010) begin
        n_fail++;
        $display("FAIL abandon_pre i=%0d got ready=%b want 0010", i, ready);
      end
      @(posedge Clk); #1;
    end
    req_valid = 4'b1000;
    #1;
    n_cmp++;
    if ({ready, pal_index} !== 13'h0) begin
      n_fail++;
      $display("FAIL abandon_bubble got ready=%b idx=%0d want 0000/0", ready, pal_index);
    end
    @(posedge Clk); #1;
    n_cmp++;
    if ({rsp_valid, rsp_id} !== {1'b0, 2'd1}) begin
      n_fail++;
      $display("FAIL abandon_bubble_rsp got v=%b id=%0d want v=0 id=1", rsp_valid, rsp_id);
    end
    #1;
    n_cmp++;
    if ({ready, pal_index} !== {4'b1000, 9'd511}) begin
      n_fail++;
      $display("FAIL abandon_next got ready=%b idx=%0d want 1000/511", ready, pal_index);
    end
    @(posedge Clk); #1;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue} !== {1'b1, 2'd3, pal_model(9'd511)}) begin
      n_fail++;
      $display("FAIL abandon_rsp got v=%b id=%0d rgb=%h%h%h want v=1 id=3 rgb=%h",
               rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue, pal_model(9'd511));
    end
    req_valid = '0;
    @(posedge Clk); #1;
  endtask

  task automatic test_contention();
    logic [1:0] g;
    logic [3:0] oh;
    req_valid = 4'b1001;
    for (int i = 0; i < 32; i++) begin
      g  = ((i / 8) % 2 == 0) ? 2'd0 : 2'd3;
      oh = 4'b0001 << g;
      #1;
      n_cmp++;
      if (ready !== oh) begin
        n_fail++;
        $display("FAIL contend_grant i=%0d got ready=%b want %b", i, ready, oh);
      end
      @(posedge Clk); #1;
      n_cmp++;
      if ({rsp_valid, rsp_id} !== {1'b1, g}) begin
        n_fail++;
        $display("FAIL contend_rsp i=%0d got v=%b id=%0d want v=1 id=%0d", i, rsp_valid, rsp_id, g);
      end
    end
    req_valid = '0;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid_burst();
    req_valid = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      #1;
      @(posedge Clk); #1;
    end
    #1;
    n_cmp++;
    if ({ready, rsp_valid, rsp_id} !== {4'b0100, 1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL midrst_pre got ready=%b v=%b id=%0d want 0100/1/2", ready, rsp_valid, rsp_id);
    end
    #1 Reset = 1'b1;
    #1;
    n_cmp++;
    if ({ready, pal_index, rsp_valid, rsp_id} !== 16'h0) begin
      n_fail++;
      $display("FAIL midrst_clear got ready=%b idx=%0d v=%b id=%0d want all zero",
               ready, pal_index, rsp_valid, rsp_id);
    end
    n_cmp++;
    if ({rsp_red, rsp_green, rsp_blue} !== 12'h0) begin
      n_fail++;
      $display("FAIL midrst_rgb got %h%h%h want 000", rsp_red, rsp_green, rsp_blue);
    end
    #1 Reset = 1'b0;
    req_valid = 4'hF;
    #1;
    n_cmp++;
    if ({ready, pal_index} !== {4'b0001, 9'd5}) begin
      n_fail++;
      $display("FAIL midrst_first got ready=%b idx=%0d want 0001/5", ready, pal_index);
    end
    @(posedge Clk); #1;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue} !== {1'b1, 2'd0, pal_model(9'd5)}) begin
      n_fail++;
      $display("FAIL midrst_rsp got v=%b id=%0d rgb=%h%h%h want v=1 id=0 rgb=%h",
               rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue, pal_model(9'd5));
    end
    req_valid = '0;
    @(posedge Clk); #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) req_index[i*IW +: IW] = idx_tab[i];
    test_reset();
    test_rotation();
    test_burst_limit();
    test_burst_abandon();
    test_contention();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
